// File: rtl/oam_dma_pkg.sv
// rtl/oam_dma_pkg.sv - shared state encoding and bus addresses for the sprite DMA
package oam_dma_pkg;

   // CPU write to this address starts a transfer; every DMA write lands here
   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
   localparam int          DMA_LEN       = 256;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: stalls the CPU and copies one page into the OAM data port
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter logic [15:0] DMA_REG  = DMA_REG_ADDR,
   parameter logic [15:0] OAM_DATA = OAM_DATA_ADDR,
   parameter int          LEN      = DMA_LEN
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ce,
   input  logic [15:0] cpu_address,
   input  logic [7:0]  cpu_out,
   input  logic        cpu_we,
   input  logic [7:0]  bus_in,
   output logic        cpu_stall,
   output logic        dma_active,
   output logic [15:0] dma_address,
   output logic [7:0]  dma_out,
   output logic        dma_we
);

   localparam int            IW       = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

   dma_state_t    state_q, state_d;
   logic [7:0]    page_q, page_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    data_q, data_d;
   logic          parity_q, parity_d;
   logic          trigger;

   assign trigger = cpu_we && (cpu_address == DMA_REG);

   // state, counters and the free-running CPU cycle parity
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         page_q   <= 8'h00;
         idx_q    <= '0;
         data_q   <= 8'h00;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         parity_q <= parity_d;
      end
   end

   // next-state on ce, and Moore outputs decoded from the current state
   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      idx_d       = idx_q;
      data_d      = data_q;
      parity_d    = parity_q;
      cpu_stall   = 1'b0;
      dma_active  = 1'b0;
      dma_we      = 1'b0;
      dma_address = 16'h0000;
      dma_out     = 8'h00;

      if (ce) begin
         parity_d = ~parity_q;
         case (state_q)
            S_IDLE: begin
               // a trigger is only honoured here, so writes during a transfer are dropped
               if (trigger) begin
                  page_d  = cpu_out;
                  idx_d   = '0;
                  state_d = S_HALT;
               end
            end
            S_HALT:  state_d = parity_q ? S_ALIGN : S_READ;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
               // memories run faster than ce, so bus_in is already valid here
               data_d  = bus_in;
               state_d = S_WRITE;
            end
            S_WRITE: begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_READ;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      case (state_q)
         S_HALT: begin
            cpu_stall = 1'b1;
         end
         S_ALIGN: begin
            cpu_stall   = 1'b1;
            dma_active  = 1'b1;
            dma_address = OAM_DATA;
         end
         S_READ: begin
            cpu_stall   = 1'b1;
            dma_active  = 1'b1;
            dma_address = {page_q, 8'(idx_q)};
         end
         S_WRITE: begin
            cpu_stall   = 1'b1;
            dma_active  = 1'b1;
            dma_we      = 1'b1;
            dma_address = OAM_DATA;
            dma_out     = data_q;
         end
         default: ;
      endcase
   end

endmodule
